// File: rtl/prog_mem_pkg.sv
// Shared types for the UART-loaded instruction memory: FSM states and byte-order constants.
package prog_mem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        FINISH
    } state_t;

    localparam bit ENDIAN_LITTLE = 1'b0;
    localparam bit ENDIAN_BIG    = 1'b1;

endpackage

// File: rtl/imem_byte_ram.sv
// Byte-wide storage with one write port and an NB-byte registered read port.
// Contents are deliberately not reset.
module imem_byte_ram #(
    parameter int unsigned DEPTH = 5120,
    parameter int unsigned NB    = 4,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            wr_en,
    input  logic [AW-1:0]   wr_addr,
    input  logic [7:0]      wr_data,
    input  logic            rd_en,
    input  logic [AW-1:0]   rd_addr,
    output logic [8*NB-1:0] rd_data
);

    logic [7:0] mem [DEPTH];

    // Caller guarantees rd_addr+NB-1 < DEPTH whenever rd_en is high.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            for (int unsigned i = 0; i < NB; i++) begin
                rd_data[8*i +: 8] <= mem[AW'(32'(rd_addr) + i)];
            end
        end
    end

endmodule

// File: rtl/prog_instr_mem.sv
// Instruction memory loaded byte-by-byte over UART during a program session,
// read as INST_BYTES-wide instructions with one cycle of latency when idle.
module prog_instr_mem
    import prog_mem_pkg::*;
#(
    parameter int unsigned MEM_KIB     = 5,
    parameter int unsigned INST_BYTES  = 4,
    parameter bit          BIG_ENDIAN  = ENDIAN_BIG,
    parameter bit          ALIGN_CHECK = 1'b1
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             prog_mode,
    input  logic                             rx_valid,
    input  logic [7:0]                       rx_data,
    input  logic                             rd_en,
    input  logic [31:0]                      addr,
    output logic [8*INST_BYTES-1:0]          inst,
    output logic                             inst_valid,
    output logic                             range_err,
    output logic                             align_err,
    output logic                             load_done,
    output logic [$clog2(MEM_KIB*1024):0]    byte_count,
    output logic [7:0]                       checksum,
    output logic                             ovf_err,
    output logic                             partial_err
);

    localparam int unsigned DEPTH = MEM_KIB * 1024;
    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned IW    = 8 * INST_BYTES;

    state_t         state;
    logic [AW:0]    ptr;
    logic [AW:0]    ptr_next;
    logic           wr_en;
    logic           rd_accept;
    logic [32:0]    rd_last;
    logic           out_of_range;
    logic           misaligned;
    logic           zero_q;
    logic [IW-1:0]  ram_q;

    // Write pointer and byte count always move together, so one register serves both.
    assign byte_count   = ptr;
    assign wr_en        = (state == LOAD) && rx_valid && (ptr < (AW+1)'(DEPTH));
    assign ptr_next     = ptr + (AW+1)'(wr_en);

    assign rd_accept    = (state == IDLE) && rd_en && !prog_mode;
    assign rd_last      = {1'b0, addr} + 33'(INST_BYTES - 1);
    assign out_of_range = rd_last >= 33'(DEPTH);
    assign misaligned   = (addr % 32'(INST_BYTES)) != '0;

    imem_byte_ram #(
        .DEPTH (DEPTH),
        .NB    (INST_BYTES),
        .AW    (AW)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (ptr[AW-1:0]),
        .wr_data (rx_data),
        .rd_en   (rd_accept && !out_of_range),
        .rd_addr (addr[AW-1:0]),
        .rd_data (ram_q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            ptr         <= '0;
            checksum    <= '0;
            ovf_err     <= 1'b0;
            partial_err <= 1'b0;
            load_done   <= 1'b0;
        end else begin
            load_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (prog_mode) begin
                        state       <= LOAD;
                        ptr         <= '0;
                        checksum    <= '0;
                        ovf_err     <= 1'b0;
                        partial_err <= 1'b0;
                    end
                end
                LOAD: begin
                    ptr <= ptr_next;
                    if (wr_en) begin
                        checksum <= checksum ^ rx_data;
                    end else if (rx_valid) begin
                        ovf_err <= 1'b1;
                    end
                    if (!prog_mode) begin
                        state       <= FINISH;
                        load_done   <= 1'b1;
                        partial_err <= (ptr_next % (AW+1)'(INST_BYTES)) != '0;
                    end
                end
                FINISH:  state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // zero_q marks that the held RAM word must not be shown (reset, range error, session).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inst_valid <= 1'b0;
            range_err  <= 1'b0;
            align_err  <= 1'b0;
            zero_q     <= 1'b1;
        end else begin
            inst_valid <= rd_accept;
            range_err  <= rd_accept && out_of_range;
            align_err  <= rd_accept && ALIGN_CHECK && misaligned;
            if (rd_accept) begin
                zero_q <= out_of_range;
            end else if (state != IDLE) begin
                zero_q <= 1'b1;
            end
        end
    end

    always_comb begin
        inst = '0;
        if (!zero_q && (state == IDLE)) begin
            for (int unsigned i = 0; i < INST_BYTES; i++) begin
                if (BIG_ENDIAN) begin
                    inst[IW-1-8*i -: 8] = ram_q[8*i +: 8];
                end else begin
                    inst[8*i +: 8] = ram_q[8*i +: 8];
                end
            end
        end
    end

endmodule
